// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller's coin payout path:
// FSM states, tube indices and the coin denomination table.
package vend_pkg;

    localparam int AMT_W_DEF = 10;
    localparam int INV_W_DEF = 8;

    localparam logic [1:0] TUBE_50 = 2'd0;
    localparam logic [1:0] TUBE_10 = 2'd1;
    localparam logic [1:0] TUBE_5  = 2'd2;
    localparam logic [1:0] TUBE_1  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE,
        ST_FAULT
    } state_t;

    // Ordered largest first so the lowest qualifying index is the greedy choice.
    localparam logic [AMT_W_DEF-1:0] DENOM [4] = '{10'd50, 10'd10, 10'd5, 10'd1};

endpackage

// File: rtl/coin_inventory.sv
// Per-tube coin counters: saturating restock, single-coin decrement on
// hopper ack, and a registered empty flag per tube.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int INV_W = INV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restock_i,
    input  logic [1:0]       restock_sel_i,
    input  logic [INV_W-1:0] restock_cnt_i,
    input  logic             dec_i,
    input  logic [1:0]       dec_sel_i,
    output logic [3:0]       avail_o,
    output logic [3:0]       inv_empty_o
);

    localparam logic [INV_W:0] SAT = {1'b0, {INV_W{1'b1}}};
    localparam logic [INV_W:0] ONE = (INV_W+1)'(1);

    logic [INV_W-1:0] inv_q [4];
    logic [INV_W-1:0] inv_d [4];
    logic [INV_W:0]   sum   [4];
    logic [3:0]       inv_empty_q;

    // One extra bit of headroom lets restock and decrement combine before clamping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = {1'b0, inv_q[i]};
            if (restock_i && restock_sel_i == 2'(i)) begin
                sum[i] = sum[i] + {1'b0, restock_cnt_i};
            end
            if (dec_i && dec_sel_i == 2'(i)) begin
                sum[i] = sum[i] - ONE;
            end
            inv_d[i] = (sum[i] > SAT) ? SAT[INV_W-1:0] : sum[i][INV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                inv_q[i] <= '0;
            end
            inv_empty_q <= 4'b1111;
        end else begin
            for (int i = 0; i < 4; i++) begin
                inv_q[i]       <= inv_d[i];
                inv_empty_q[i] <= (inv_q[i] == '0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            avail_o[i] = (inv_q[i] != '0);
        end
    end

    assign inv_empty_o = inv_empty_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer: drives the shared hopper one coin at a time
// over req/ack, reports the unpaid remainder, and faults on a silent hopper.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W   = AMT_W_DEF,
    parameter int INV_W   = INV_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    input  logic             restock,
    input  logic [1:0]       restock_sel,
    input  logic [INV_W-1:0] restock_cnt,
    output logic [3:0]       inv_empty,
    output logic             fault,
    input  logic             fault_clr
);

    localparam int           TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    state_t           state_q;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] shortfall_q;
    logic [1:0]       sel_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             fault_q;
    logic [TW-1:0]    tmo_q;

    logic [3:0]       avail;
    logic             pick_ok;
    logic [1:0]       pick_idx;
    logic             ack_ok;

    assign ack_ok = (state_q == ST_ISSUE) && req_q && coin_ack;

    // Scanning downward leaves the lowest qualifying index, i.e. the largest coin.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (avail[i] && (AMT_W'(DENOM[i]) <= remaining_q)) begin
                pick_ok  = 1'b1;
                pick_idx = 2'(i);
            end
        end
    end

    coin_inventory #(
        .INV_W(INV_W)
    ) u_inv (
        .clk          (clk),
        .reset        (reset),
        .restock_i    (restock),
        .restock_sel_i(restock_sel),
        .restock_cnt_i(restock_cnt),
        .dec_i        (ack_ok),
        .dec_sel_i    (sel_q),
        .avail_o      (avail),
        .inv_empty_o  (inv_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            sel_q       <= 2'd0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= amount;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (pick_ok) begin
                        sel_q   <= pick_idx;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_ISSUE;
                    end else begin
                        done_q      <= 1'b1;
                        shortfall_q <= remaining_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (ack_ok) begin
                        remaining_q <= remaining_q - AMT_W'(DENOM[sel_q]);
                        req_q       <= 1'b0;
                        state_q     <= ST_SELECT;
                    end else if (tmo_q == TMO_LAST) begin
                        req_q       <= 1'b0;
                        fault_q     <= 1'b1;
                        shortfall_q <= remaining_q;
                        state_q     <= ST_FAULT;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        remaining_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign shortfall = shortfall_q;
    assign coin_req  = req_q;
    assign coin_sel  = sel_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout order, shortfall,
// latency, hopper timeout, inventory saturation and mid-payout reset.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] amount = '0;
    logic       busy;
    logic       done;
    logic [9:0] shortfall;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack = 1'b0;
    logic       restock = 1'b0;
    logic [1:0] restock_sel = '0;
    logic [7:0] restock_cnt = '0;
    logic [3:0] inv_empty;
    logic       fault;
    logic       fault_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int doneCount = 0;
    int selLog [8];

    change_dispenser #(.AMT_W(10), .INV_W(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .shortfall  (shortfall),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .coin_ack   (coin_ack),
        .restock    (restock),
        .restock_sel(restock_sel),
        .restock_cnt(restock_cnt),
        .inv_empty  (inv_empty),
        .fault      (fault),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) doneCount++;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic applyRestock(input logic [1:0] sel, input logic [7:0] cnt);
        restock = 1'b1;
        restock_sel = sel;
        restock_cnt = cnt;
        step();
        restock = 1'b0;
    endtask

    // Drives one payout, acking each coin in its first request cycle; cycle
    // indices are counted from the cycle after start is sampled.
    task automatic applyStimulus(input logic [9:0] amt, input bit restockOnAck,
                                 input logic [1:0] rsel, input logic [7:0] rcnt,
                                 output int nCoins, output int firstReq,
                                 output int doneAt, output logic [9:0] sf);
        start = 1'b1;
        amount = amt;
        step();
        start = 1'b0;
        nCoins = 0;
        firstReq = -1;
        doneAt = -1;
        sf = '0;
        for (int c = 0; c < 300; c++) begin
            if (coin_ack) begin
                coin_ack = 1'b0;
                restock = 1'b0;
            end else if (coin_req) begin
                if (firstReq < 0) firstReq = c;
                if (nCoins < 8) selLog[nCoins] = int'(coin_sel);
                nCoins++;
                coin_ack = 1'b1;
                if (restockOnAck) begin
                    restock = 1'b1;
                    restock_sel = rsel;
                    restock_cnt = rcnt;
                end
            end
            if (done) begin
                doneAt = c;
                sf = shortfall;
                break;
            end
            step();
        end
        if (doneAt < 0) checkOutput("payoutNeverDone", 0, 1);
        coin_ack = 1'b0;
        restock = 1'b0;
    endtask

    task automatic waitCoinReq(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (coin_req) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) checkOutput("coinReqNeverSeen", 0, 1);
    endtask

    initial begin
        int nCoins, firstReq, doneAt, cyc, doneBefore;
        logic [9:0] sf;
        bit seen;
        int expSel [5] = '{0, 1, 2, 3, 3};

        applyReset();
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstShortfall", int'(shortfall), 0);
        checkOutput("rstCoinReq", int'(coin_req), 0);
        checkOutput("rstFault", int'(fault), 0);
        checkOutput("rstInvEmpty", int'(inv_empty), 15);

        // Greedy payout of 67 across all four tubes.
        applyRestock(2'd0, 8'd2);
        applyRestock(2'd1, 8'd5);
        applyRestock(2'd2, 8'd5);
        applyRestock(2'd3, 8'd5);
        applyStimulus(10'd67, 1'b0, 2'd0, 8'd0, nCoins, firstReq, doneAt, sf);
        checkOutput("g67Coins", nCoins, 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("g67Sel%0d", i), selLog[i], expSel[i]);
        checkOutput("g67FirstReqLatency", firstReq, 1);
        checkOutput("g67Shortfall", int'(sf), 0);
        checkOutput("g67BusyAtDone", int'(busy), 1);
        step();
        checkOutput("g67BusyAfter", int'(busy), 0);
        step();
        checkOutput("g67Inv50", int'(dut.u_inv.inv_q[0]), 1);
        checkOutput("g67Inv10", int'(dut.u_inv.inv_q[1]), 4);
        checkOutput("g67Inv5", int'(dut.u_inv.inv_q[2]), 4);
        checkOutput("g67Inv1", int'(dut.u_inv.inv_q[3]), 3);
        checkOutput("g67InvEmpty", int'(inv_empty), 0);

        // Only one 10 available for 25: pays 10, leaves 15 unpaid.
        applyReset();
        applyRestock(2'd1, 8'd1);
        applyStimulus(10'd25, 1'b0, 2'd0, 8'd0, nCoins, firstReq, doneAt, sf);
        checkOutput("s25Coins", nCoins, 1);
        checkOutput("s25Sel", selLog[0], 1);
        checkOutput("s25Shortfall", int'(sf), 15);
        step();
        step();
        checkOutput("s25InvEmpty", int'(inv_empty), 15);

        // Zero amount: no coins, done two cycles after start.
        applyStimulus(10'd0, 1'b0, 2'd0, 8'd0, nCoins, firstReq, doneAt, sf);
        checkOutput("z0Coins", nCoins, 0);
        checkOutput("z0DoneLatency", doneAt, 1);
        checkOutput("z0Shortfall", int'(sf), 0);

        // Hopper never acks: fault after 16 ISSUE cycles, clear without done.
        applyReset();
        applyRestock(2'd0, 8'd1);
        doneBefore = doneCount;
        start = 1'b1;
        amount = 10'd60;
        step();
        start = 1'b0;
        waitCoinReq(seen);
        cyc = 0;
        for (int c = 0; c < 40 && !fault; c++) begin
            step();
            cyc++;
        end
        checkOutput("tmoCycles", cyc, 16);
        checkOutput("tmoFault", int'(fault), 1);
        checkOutput("tmoCoinReq", int'(coin_req), 0);
        checkOutput("tmoShortfall", int'(shortfall), 60);
        checkOutput("tmoBusy", int'(busy), 1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        checkOutput("clrFault", int'(fault), 0);
        checkOutput("clrBusy", int'(busy), 0);
        step();
        step();
        checkOutput("clrNoDone", doneCount - doneBefore, 0);

        // Restock colliding with ack on a full tube must saturate.
        applyReset();
        applyRestock(2'd1, 8'd255);
        applyStimulus(10'd10, 1'b1, 2'd1, 8'd10, nCoins, firstReq, doneAt, sf);
        checkOutput("sat255Coins", nCoins, 1);
        checkOutput("sat255Shortfall", int'(sf), 0);
        checkOutput("sat255Inv", int'(dut.u_inv.inv_q[1]), 255);

        applyReset();
        applyRestock(2'd3, 8'd4);
        applyStimulus(10'd1, 1'b1, 2'd3, 8'd10, nCoins, firstReq, doneAt, sf);
        checkOutput("net4Coins", nCoins, 1);
        checkOutput("net4Sel", selLog[0], 3);
        checkOutput("net4Inv", int'(dut.u_inv.inv_q[3]), 13);

        // Reset during an outstanding request aborts silently.
        applyReset();
        applyRestock(2'd0, 8'd1);
        doneBefore = doneCount;
        start = 1'b1;
        amount = 10'd50;
        step();
        start = 1'b0;
        waitCoinReq(seen);
        reset = 1'b1;
        step();
        checkOutput("midRstCoinReq", int'(coin_req), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstCoinSel", int'(coin_sel), 0);
        checkOutput("midRstFault", int'(fault), 0);
        checkOutput("midRstInvEmpty", int'(inv_empty), 15);
        reset = 1'b0;
        step();
        checkOutput("midRstNoDone", doneCount - doneBefore, 0);
        applyStimulus(10'd5, 1'b0, 2'd0, 8'd0, nCoins, firstReq, doneAt, sf);
        checkOutput("emptyCoins", nCoins, 0);
        checkOutput("emptyShortfall", int'(sf), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequences coin payout for the vending controller. It accepts a refund amount and drives a shared 4-tube coin hopper one coin at a time with a req/ack handshake. Coin choice is greedy, largest denomination first, and skips any empty tube. It tracks per-tube inventory, reports any amount it could not pay, and faults if the hopper does not acknowledge in time.

Parameters:
AMT_W, 10, width of the amount and shortfall buses
INV_W, 8, width of each per-tube inventory counter
TIMEOUT, 16, cycles to wait in ISSUE for coin_ack before faulting (must be >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  request a payout; sampled only in IDLE
amount  in  AMT_W  payout value; captured with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a payout ends
shortfall  out  AMT_W  unpaid remainder; valid with done, held until the next start
coin_req  out  1  hopper request
coin_sel  out  2  tube index: 0=50, 1=10, 2=5, 3=1; stable while coin_req is high
coin_ack  in  1  hopper has ejected one coin; ignored unless coin_req is high
restock  in  1  add restock_cnt coins to tube restock_sel; accepted in any state
restock_sel  in  2  tube index
restock_cnt  in  INV_W  coins added
inv_empty  out  4  bit i high when inventory[i]==0
fault  out  1  high in FAULT
fault_clr  in  1  leaves FAULT

Behaviour:
- Reset values: all outputs 0, except inv_empty=4'b1111. All inventory=0, remaining=0, state=IDLE. Reset mid-payout aborts it with no done pulse.
- States: IDLE, SELECT, ISSUE, DONE, FAULT.
- IDLE: if start, load remaining<=amount and go to SELECT. Ignore start in all other states.
- SELECT (one cycle):
  - Pick the lowest index i with denom[i]<=remaining and inventory[i]!=0.
  - If one exists, latch coin_sel=i and go to ISSUE.
  - If remaining==0 or no tube qualifies, go to DONE.
- ISSUE: coin_req=1 and the timeout counter increments from 0.
  - On coin_ack: remaining-=denom[coin_sel], inventory[coin_sel]-=1, coin_req drops the next cycle, go to SELECT.
  - If the counter reaches TIMEOUT-1 without ack, go to FAULT.
  - Each coin costs 2 cycles minimum (ISSUE with ack, then SELECT).
- DONE (one cycle): done=1, shortfall=remaining, then IDLE.
- FAULT: fault=1, coin_req=0, shortfall=remaining. On fault_clr go to IDLE with no done pulse; remaining is discarded.
- Latency: start in cycle N gives coin_req in cycle N+2. For amount=0, done is in cycle N+2.
- Inventory arithmetic:
  - Restock adds and saturates at 2^INV_W-1.
  - Restock and ack-decrement on the same tube in the same cycle give a net of +cnt-1, saturating.
  - Restock is visible to SELECT the cycle after it is applied.
- Underflow cannot occur: SELECT never picks an empty tube.
- inv_empty is registered from the updated inventory and lags by one cycle.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package vend_pkg holds:
  - state enum
  - tube index constants
  - denomination table DENOM[0:3]={50,10,5,1} at AMT_W bits
  - INV_W default
- One sub-module, coin_inventory: four saturating counters with restock/decrement ports and inv_empty.

Test Plan:
- Restock 50:2, 10:5, 5:5, 1:5; start amount=67 → coin_sel sequence 0,1,2,3,3 with ack after 1 cycle each; done with shortfall=0; then inv 50:1, 10:4, 5:4, 1:3.
- Inventory only 10:1; amount=25 → one coin (sel 1); done with shortfall=15; inv_empty=4'b1111.
- amount=0 → no coin_req; done exactly 2 cycles after start; shortfall=0.
- Hold coin_ack=0 for TIMEOUT=16 cycles in ISSUE → fault=1, coin_req=0, shortfall=remaining; fault_clr → IDLE, busy=0, no done.
- Tube 1 at 255: restock sel 1, cnt 10 in the same cycle as ack on sel 1 → inventory=255, not wrapped. Separately, tube 3 at 4: same stimulus on sel 3 → 13.
- Assert reset while coin_req=1 → next cycle all outputs are at reset values; a later start with amount=5 and empty tubes gives shortfall=5.
